xbus_request_ctl: RTL and testbench
===================================

Name: xbus_request_ctl

Overview:
- Bus master / watchdog sitting directly upstream of the Xbus/Unibus device slaves (Unibus register slave, memory, spy/other decoders).
- Accepts one CPU memory-cycle request at a time, broadcasts it to NDEV slaves, and selects the slave that asserts decode.
- Returns that slave's data and ack to the CPU.
- If no slave decodes, or the selected slave never acks, issues a one-cycle timeout pulse to all slaves (address still held, so slaves can latch NXM status) and completes the CPU cycle with an NXM indication.

Parameters:
- NDEV, 4, number of slave devices on the bus (1..8)
- DECODE_WAIT, 4, cycles bus_req is held with no decode before timeout (1..255)
- ACK_WAIT, 64, cycles after decode with no ack before timeout (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU request, level, 4-phase handshake
- cpu_write  in  1  1 = write, 0 = read
- cpu_addr  in  22  word address
- cpu_data_in  in  32  write data
- cpu_ack  out  1  cycle complete, held until cpu_req drops
- cpu_data_out  out  32  read data, valid while cpu_ack = 1
- cpu_nxm  out  1  cycle ended by timeout, valid while cpu_ack = 1
- busy  out  1  state != IDLE
- bus_req  out  1  request to slaves
- bus_write  out  1  latched cpu_write
- bus_addr  out  22  latched cpu_addr
- bus_data  out  32  latched cpu_data_in
- timeout  out  1  one-cycle timeout pulse to slaves
- dev_decode  in  NDEV  per-slave combinational decode
- dev_ack  in  NDEV  per-slave ack
- dev_data  in  32*NDEV  packed slave read data; slave i occupies bits [32i+31:32i]
- decode_conflict  out  1  one-cycle pulse when more than one decode is seen

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs go to 0; bus_addr, bus_data and the counter clear.
- FSM states: IDLE, DECODE, WAIT_ACK, TIMEOUT, DONE.
- IDLE:
  - On a clk edge with cpu_req = 1, latch cpu_addr, cpu_data_in and cpu_write into bus_addr, bus_data and bus_write.
  - Clear the counter and go to DECODE.
- DECODE:
  - bus_req = 1 and the counter increments each cycle.
  - If any dev_decode bit = 1: select the lowest-index decoding slave, clear the counter, go to WAIT_ACK.
  - If more than one decode bit is set, pulse decode_conflict for one cycle.
  - Else, if counter = DECODE_WAIT-1, go to TIMEOUT.
  - Net effect: with no decode, bus_req is high for exactly DECODE_WAIT cycles.
- WAIT_ACK:
  - bus_req stays 1, because slaves derive ack from a held decode.
  - When the selected slave's dev_ack = 1:
    - on a read, capture its dev_data slice into cpu_data_out;
    - on a write, set cpu_data_out = 0;
    - go to DONE.
  - Else, if counter = ACK_WAIT-1, go to TIMEOUT.
  - Acks from unselected slaves are ignored.
- TIMEOUT:
  - Lasts exactly one cycle: bus_req = 0, timeout = 1, bus_addr still held.
  - Sets cpu_data_out = 0 and the internal nxm flag = 1, then goes to DONE.
- DONE:
  - bus_req = 0; cpu_ack = 1; cpu_nxm = nxm flag.
  - Stays in DONE while cpu_req = 1.
  - When cpu_req = 0: clear cpu_ack, cpu_nxm and cpu_data_out, then go to IDLE.
  - A new request therefore needs at least one cpu_req-low cycle.
- Latency: cpu_ack is registered and rises on the edge after the selected ack is sampled high. A slave acking 2 cycles after decode gives cpu_ack 4 cycles after the IDLE-accept edge.
- All FSM outputs and the counter are registered; dev_* inputs are sampled only in DECODE and WAIT_ACK.
- cpu_req dropping mid-cycle (before DONE) is ignored; the bus cycle runs to completion.
- Reset mid-operation aborts immediately: bus_req and timeout drop and no ack is issued.
- Counter is 8 bits and does not wrap in practice, since the WAIT limits are ≤ 255.

Decomposition:
- Shared package xbus_pkg:
  - state encoding type;
  - default DECODE_WAIT / ACK_WAIT;
  - address constants: Unibus register base 22'o17773000, Unibus NXM threshold 22'o17400000, Xbus NXM threshold 22'o17000000.
- One natural sub-module, xbus_wdog: loadable 8-bit counter with a clear input and a limit-compare output. Both wait states reuse it.

Test Plan:
- Read 17773022 against the Unibus slave at index 0, status clear: cpu_ack rises, cpu_data_out = 0, cpu_nxm = 0, timeout never asserted, bus_req high continuously from DECODE until DONE.
- Write 17773005 with data 045: promdisable pulses in the slave, and cpu_ack follows with cpu_nxm = 0.
- Read 17600000 with no decoder: bus_req is high for 4 cycles, then timeout = 1 for one cycle with bus_addr = 17600000. cpu_ack follows with cpu_nxm = 1 and data 0. A subsequent read of 17773022 returns 010 (Unibus NXM).
- Read 17100000 with no decoder: timeout fires; a subsequent 17773022 read returns 001. A write to 17773022 followed by a reread returns 0.
- Slave decodes but never acks: timeout occurs exactly ACK_WAIT cycles after decode and cpu_nxm = 1. Holding cpu_req high keeps cpu_ack high; no second cycle starts until cpu_req drops.
- Two slaves decode together: the lowest index is selected and decode_conflict pulses once. Asserting reset in WAIT_ACK drops bus_req asynchronously and no cpu_ack is produced.

Source files
------------

// File: rtl/xbus_pkg.sv
// rtl/xbus_pkg.sv - shared state type, wait defaults and address map for the Xbus request controller
package xbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_TIMEOUT  = 3'd3,
    ST_DONE     = 3'd4
  } xbus_state_t;

  localparam int DEFAULT_DECODE_WAIT = 4;
  localparam int DEFAULT_ACK_WAIT    = 64;

  localparam logic [21:0] UNIBUS_REG_BASE = 22'o17773000;
  localparam logic [21:0] UNIBUS_NXM_BASE = 22'o17400000;
  localparam logic [21:0] XBUS_NXM_BASE   = 22'o17000000;

  // Watchdog compare value for a wait of the given length in cycles.
  function automatic logic [7:0] wait_limit(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/xbus_wdog.sv
// rtl/xbus_wdog.sv - 8-bit cycle counter with synchronous clear and limit compare
module xbus_wdog (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       at_limit
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/xbus_request_ctl.sv
// rtl/xbus_request_ctl.sv - Xbus master: broadcasts one CPU cycle to the slaves, selects the decoder,
// returns its data/ack, and ends undecoded or unacked cycles with a timeout pulse and NXM.
module xbus_request_ctl
  import xbus_pkg::*;
#(
  parameter int NDEV        = 4,
  parameter int DECODE_WAIT = DEFAULT_DECODE_WAIT,
  parameter int ACK_WAIT    = DEFAULT_ACK_WAIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_write,
  input  logic [21:0]          cpu_addr,
  input  logic [31:0]          cpu_data_in,
  output logic                 cpu_ack,
  output logic [31:0]          cpu_data_out,
  output logic                 cpu_nxm,
  output logic                 busy,
  output logic                 bus_req,
  output logic                 bus_write,
  output logic [21:0]          bus_addr,
  output logic [31:0]          bus_data,
  output logic                 timeout,
  input  logic [NDEV-1:0]      dev_decode,
  input  logic [NDEV-1:0]      dev_ack,
  input  logic [32*NDEV-1:0]   dev_data,
  output logic                 decode_conflict
);

  localparam int SW = (NDEV > 1) ? $clog2(NDEV) : 1;

  xbus_state_t state, next_state;
  logic [SW-1:0] sel, lowest;
  logic          any_decode, sel_ack, wd_clear, wd_enable, wd_at_limit;
  logic [7:0]    wd_limit;
  logic [31:0]   sel_data, cpu_data_d;
  logic          bus_req_d, timeout_d, busy_d, cpu_ack_d, cpu_nxm_d, conflict_d;

  always_comb begin
    lowest = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (dev_decode[i]) lowest = SW'(i);
    end
  end

  assign any_decode = |dev_decode;
  assign sel_ack    = dev_ack[sel];
  assign sel_data   = dev_data[32*int'(sel) +: 32];

  // One counter serves both waits; it restarts on accept and again when a slave decodes.
  assign wd_limit  = (state == ST_DECODE) ? wait_limit(DECODE_WAIT) : wait_limit(ACK_WAIT);
  assign wd_clear  = (state == ST_IDLE) || (state == ST_DECODE && any_decode);
  assign wd_enable = (state == ST_DECODE) || (state == ST_WAIT_ACK);

  xbus_wdog u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .limit    (wd_limit),
    .at_limit (wd_at_limit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      sel             <= '0;
      bus_write       <= 1'b0;
      bus_addr        <= '0;
      bus_data        <= '0;
      bus_req         <= 1'b0;
      timeout         <= 1'b0;
      busy            <= 1'b0;
      cpu_ack         <= 1'b0;
      cpu_nxm         <= 1'b0;
      cpu_data_out    <= '0;
      decode_conflict <= 1'b0;
    end else begin
      state           <= next_state;
      bus_req         <= bus_req_d;
      timeout         <= timeout_d;
      busy            <= busy_d;
      cpu_ack         <= cpu_ack_d;
      cpu_nxm         <= cpu_nxm_d;
      cpu_data_out    <= cpu_data_d;
      decode_conflict <= conflict_d;
      if (state == ST_IDLE && cpu_req) begin
        bus_write <= cpu_write;
        bus_addr  <= cpu_addr;
        bus_data  <= cpu_data_in;
      end
      if (state == ST_DECODE && any_decode) sel <= lowest;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (cpu_req) next_state = ST_DECODE;
      ST_DECODE:   if (any_decode) next_state = ST_WAIT_ACK;
                   else if (wd_at_limit) next_state = ST_TIMEOUT;
      ST_WAIT_ACK: if (sel_ack) next_state = ST_DONE;
                   else if (wd_at_limit) next_state = ST_TIMEOUT;
      ST_TIMEOUT:  next_state = ST_DONE;
      ST_DONE:     if (!cpu_req) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered so they line up with it.
  always_comb begin
    bus_req_d  = (next_state == ST_DECODE) || (next_state == ST_WAIT_ACK);
    timeout_d  = (next_state == ST_TIMEOUT);
    busy_d     = (next_state != ST_IDLE);
    cpu_ack_d  = (next_state == ST_DONE);
    cpu_nxm_d  = (next_state == ST_DONE) && ((state == ST_TIMEOUT) || cpu_nxm);
    conflict_d = (state == ST_DECODE) && ($countones(dev_decode) > 1);
    cpu_data_d = cpu_data_out;
    case (state)
      ST_WAIT_ACK: if (sel_ack) cpu_data_d = bus_write ? 32'h0 : sel_data;
      ST_TIMEOUT:  cpu_data_d = 32'h0;
      ST_DONE:     if (!cpu_req) cpu_data_d = 32'h0;
      default:     cpu_data_d = cpu_data_out;
    endcase
  end

endmodule

// File: tb/tb_xbus_request_ctl.sv
// tb/tb_xbus_request_ctl.sv - randomized bench for xbus_request_ctl with behavioural slaves and outcome model
module tb_xbus_request_ctl;
  import xbus_pkg::*;

  localparam int NDEV  = 4;
  localparam int DW    = DEFAULT_DECODE_WAIT;
  localparam int AW    = DEFAULT_ACK_WAIT;
  localparam int NEVER = 1000;
  localparam int LIMIT = 300;
  localparam logic [21:0] UNI_STATUS = UNIBUS_REG_BASE + 22'o22;

  logic               clk = 1'b0;
  logic               reset;
  logic               cpu_req, cpu_write;
  logic [21:0]        cpu_addr;
  logic [31:0]        cpu_data_in;
  logic               cpu_ack, cpu_nxm, busy, bus_req, bus_write, timeout, decode_conflict;
  logic [31:0]        cpu_data_out, bus_data;
  logic [21:0]        bus_addr;
  logic [NDEV-1:0]    dev_decode, dev_ack;
  logic [32*NDEV-1:0] dev_data;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xbus_request_ctl #(.NDEV(NDEV), .DECODE_WAIT(DW), .ACK_WAIT(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_ack(cpu_ack), .cpu_data_out(cpu_data_out), .cpu_nxm(cpu_nxm), .busy(busy),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr), .bus_data(bus_data),
    .timeout(timeout), .dev_decode(dev_decode), .dev_ack(dev_ack), .dev_data(dev_data),
    .decode_conflict(decode_conflict)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave models: random-mode slaves decode per mask and ack (registered) ack_dly cycles after
  // first decode; unibus mode has one status slave at index 0 that records NXM timeouts.
  logic            uni_mode;
  logic [NDEV-1:0] dec_mask, ack_noise;
  int              ack_dly [NDEV];
  logic [31:0]     rdata [NDEV];
  int              dcnt [NDEV] = '{default: 0};
  logic [31:0]     uni_status;

  always_comb begin
    dev_decode = '0;
    dev_ack    = '0;
    dev_data   = '0;
    if (bus_req) begin
      if (uni_mode) dev_decode[0] = (bus_addr >= UNIBUS_REG_BASE) && (bus_addr < UNIBUS_REG_BASE + 22'd64);
      else dev_decode = dec_mask;
    end
    for (int i = 0; i < NDEV; i++) begin
      dev_ack[i] = (dev_decode[i] && dcnt[i] >= ack_dly[i] + 1) || ack_noise[i];
      dev_data[32*i +: 32] = rdata[i];
    end
    if (uni_mode) dev_data[31:0] = (bus_addr == UNI_STATUS) ? uni_status : 32'h0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < NDEV; i++) dcnt[i] <= dev_decode[i] ? dcnt[i] + 1 : 0;
    if (reset) uni_status <= 32'h0;
    else if (timeout) begin
      if (bus_addr >= UNIBUS_NXM_BASE) uni_status <= uni_status | 32'o10;
      else if (bus_addr >= XBUS_NXM_BASE) uni_status <= uni_status | 32'o1;
    end else if (uni_mode && dev_ack[0] && bus_write && bus_addr == UNI_STATUS) uni_status <= 32'h0;
  end

  // Runs one CPU cycle from a negedge with the controller idle; latency is counted in edges
  // from the accepting edge to the edge that raises cpu_ack.
  task automatic run_cycle(input logic [21:0] addr, input logic wr, input logic [31:0] wdata, input bit early,
                           input logic [31:0] e_data, input logic e_nxm, input int e_lat,
                           input int e_breq, input int e_to, input int e_conf);
    int k = 0, breq = 0, to = 0, conf = 0, addr_bad = 0, hold_bad = 0;
    bit acked = 0;
    cpu_addr = addr; cpu_write = wr; cpu_data_in = wdata; cpu_req = 1'b1;
    @(posedge clk);
    while (!acked && k <= LIMIT) begin
      @(negedge clk);
      if (early) cpu_req = 1'b0;
      if (cpu_ack) acked = 1;
      else begin
        breq += int'(bus_req);
        to   += int'(timeout);
        conf += int'(decode_conflict);
        if (timeout && bus_addr !== addr) addr_bad++;
        @(posedge clk);
        k++;
      end
    end
    check("ack_seen", acked, 1);
    check("ack_latency", k, e_lat);
    check("cpu_nxm", cpu_nxm, e_nxm);
    check("cpu_data_out", cpu_data_out, e_data);
    check("bus_req_cycles", breq, e_breq);
    check("timeout_pulses", to, e_to);
    check("timeout_addr_held", addr_bad, 0);
    check("conflict_pulses", conf, e_conf);
    check("busy_in_done", busy, 1);
    if (!early) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk); @(negedge clk);
        if (cpu_ack !== 1'b1 || bus_req !== 1'b0 || busy !== 1'b1) hold_bad++;
      end
      check("done_hold", hold_bad, 0);
      cpu_req = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    check("release", {cpu_ack, cpu_nxm, busy, cpu_data_out}, 0);
  endtask

  initial begin
    logic [NDEV-1:0] m;
    logic [21:0]     a;
    logic [31:0]     e_data;
    logic            wr, e_nxm;
    int              s, e_lat, e_breq, e_to, bad;
    reset = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_data_in = '0;
    uni_mode = 1'b1; dec_mask = '0; ack_noise = '0;
    for (int i = 0; i < NDEV; i++) begin ack_dly[i] = 1; rdata[i] = 32'h0; end
    repeat (3) @(negedge clk);
    check("rst_ctrl", {cpu_ack, cpu_nxm, busy, bus_req, bus_write, timeout, decode_conflict}, 0);
    check("rst_cpu_data_out", cpu_data_out, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_data", bus_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // Unibus status register scenario
    run_cycle(UNI_STATUS, 1'b0, 32'h0, 0, 32'h0, 1'b0, 3, 3, 0, 0);
    run_cycle(22'o17773005, 1'b1, 32'o45, 0, 32'h0, 1'b0, 3, 3, 0, 0);
    run_cycle(22'o17600000, 1'b0, 32'h0, 0, 32'h0, 1'b1, DW + 1, DW, 1, 0);
    run_cycle(UNI_STATUS, 1'b0, 32'h0, 0, 32'o10, 1'b0, 3, 3, 0, 0);
    run_cycle(UNI_STATUS, 1'b1, 32'h0, 0, 32'h0, 1'b0, 3, 3, 0, 0);
    run_cycle(UNI_STATUS, 1'b0, 32'h0, 1, 32'h0, 1'b0, 3, 3, 0, 0);
    run_cycle(22'o17100000, 1'b0, 32'h0, 0, 32'h0, 1'b1, DW + 1, DW, 1, 0);
    run_cycle(UNI_STATUS, 1'b0, 32'h0, 0, 32'o1, 1'b0, 3, 3, 0, 0);

    // Randomized slave populations
    uni_mode = 1'b0;
    for (int t = 0; t < 40; t++) begin
      m = (t % 8 == 0) ? '0 : NDEV'($urandom);
      for (int i = 0; i < NDEV; i++) begin
        ack_dly[i] = $urandom_range(0, 6);
        rdata[i]   = $urandom;
        if (t % 7 == 3) ack_dly[i] = NEVER;
        if (t == 5) ack_dly[i] = AW - 1;
        if (t == 6) ack_dly[i] = AW;
      end
      s = 0;
      for (int i = NDEV - 1; i >= 0; i--) if (m[i]) s = i;
      dec_mask  = m;
      ack_noise = NDEV'($urandom) & ~(NDEV'(1) << s);
      wr = 1'($urandom);
      a  = 22'($urandom);
      if (m == '0) begin
        e_lat = DW + 1; e_breq = DW; e_to = 1; e_nxm = 1'b1; e_data = 32'h0;
      end else if (ack_dly[s] >= AW) begin
        e_lat = AW + 2; e_breq = AW + 1; e_to = 1; e_nxm = 1'b1; e_data = 32'h0;
      end else begin
        e_lat = 2 + ack_dly[s]; e_breq = e_lat; e_to = 0; e_nxm = 1'b0;
        e_data = wr ? 32'h0 : rdata[s];
      end
      run_cycle(a, wr, $urandom, ($urandom_range(0, 4) == 0), e_data, e_nxm, e_lat, e_breq, e_to,
                ($countones(m) > 1) ? 1 : 0);
    end

    // Reset while waiting for an ack aborts the cycle without an ack
    dec_mask = 4'b0110; ack_noise = '0;
    for (int i = 0; i < NDEV; i++) ack_dly[i] = NEVER;
    cpu_addr = 22'o17000100; cpu_write = 1'b0; cpu_req = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_bus_req", bus_req, 0);
    check("rst_mid_busy", busy, 0);
    bad = 0;
    repeat (3) begin @(negedge clk); if (cpu_ack !== 1'b0) bad++; end
    cpu_req = 1'b0; reset = 1'b0;
    repeat (3) begin @(negedge clk); if (cpu_ack !== 1'b0 || busy !== 1'b0) bad++; end
    check("rst_mid_no_ack", bad, 0);

    // Recovery: slave acking two cycles after decode completes four edges after accept
    dec_mask = 4'b0001; ack_dly[0] = 2; rdata[0] = 32'hCAFE_0123;
    run_cycle(22'o17773022, 1'b0, 32'h0, 0, 32'hCAFE_0123, 1'b0, 4, 4, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
